// File: rtl/stream_dot_pkg.sv
// Shared types and helpers for the streaming signed dot-product operator.
// Holds the FSM state encoding, default widths and the result word splitter.
package stream_dot_pkg;

    localparam int DATA_BITS_DEF = 32;
    localparam int ACC_BITS_DEF  = 64;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        OUT   = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_BITS_DEF-1:0] hi;
        logic [DATA_BITS_DEF-1:0] lo;
    } result_words_t;

    function automatic result_words_t split_result(input logic [ACC_BITS_DEF-1:0] r);
        result_words_t w;
        w.hi = r[ACC_BITS_DEF-1:DATA_BITS_DEF];
        w.lo = r[DATA_BITS_DEF-1:0];
        return w;
    endfunction

endpackage

// File: rtl/stream_dot_mac.sv
// Product register followed by a wrapping accumulator with synchronous clear.
// A product accepted in cycle T lands in the accumulator at the end of T+1.
module stream_dot_mac
    import stream_dot_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int ACC_BITS  = 2 * DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 accept,
    input  logic                 clear,
    input  logic [DATA_BITS-1:0] a,
    input  logic [DATA_BITS-1:0] b,
    output logic                 prod_vld,
    output logic [ACC_BITS-1:0]  acc
);

    logic [ACC_BITS-1:0] a_ext;
    logic [ACC_BITS-1:0] b_ext;
    logic [ACC_BITS-1:0] prod_reg;
    logic [ACC_BITS-1:0] acc_reg;
    logic                prod_vld_reg;

    // Sign-extend to full width so the low ACC_BITS of the product are exact.
    assign a_ext = {{DATA_BITS{a[DATA_BITS-1]}}, a};
    assign b_ext = {{DATA_BITS{b[DATA_BITS-1]}}, b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_reg     <= '0;
            prod_vld_reg <= 1'b0;
            acc_reg      <= '0;
        end else begin
            prod_vld_reg <= accept;
            if (accept) begin
                prod_reg <= a_ext * b_ext;
            end
            if (clear) begin
                acc_reg <= '0;
            end else if (prod_vld_reg) begin
                acc_reg <= acc_reg + prod_reg;
            end
        end
    end

    assign prod_vld = prod_vld_reg;
    assign acc      = acc_reg;

endmodule

// File: rtl/stream_dot_product.sv
// Streaming signed dot product over VEC_LEN pairs; 64-bit result split across two output streams.
// Optional STREAM_DOT_VECCNT_EN adds a vec_count port counting completed results.
module stream_dot_product
    import stream_dot_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int VEC_LEN   = 8
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic                 ap_start,
    output logic                 ap_idle,
    output logic                 ap_done,
    output logic                 ap_ready,
    input  logic [DATA_BITS-1:0] Input_1_V_V,
    input  logic                 Input_1_V_V_ap_vld,
    output logic                 Input_1_V_V_ap_ack,
    input  logic [DATA_BITS-1:0] Input_2_V_V,
    input  logic                 Input_2_V_V_ap_vld,
    output logic                 Input_2_V_V_ap_ack,
    output logic [DATA_BITS-1:0] Output_1_V_V,
    output logic                 Output_1_V_V_ap_vld,
    input  logic                 Output_1_V_V_ap_ack,
    output logic [DATA_BITS-1:0] Output_2_V_V,
    output logic                 Output_2_V_V_ap_vld,
    input  logic                 Output_2_V_V_ap_ack
`ifdef STREAM_DOT_VECCNT_EN
   ,output logic [31:0]          vec_count
`endif
);

    localparam int ACC_BITS = 2 * DATA_BITS;
    localparam int CNT_BITS = $clog2(VEC_LEN + 1);

    state_t                state_reg, state_next;
    logic [CNT_BITS-1:0]   count_reg, count_next;
    logic                  done_reg, done_next;
    logic                  accept, load, clear, prod_vld;
    logic [ACC_BITS-1:0]   acc;
    logic [1:0]            out_ack, out_vld, lane_free;
    logic [DATA_BITS-1:0]  result_word [2];
    logic [DATA_BITS-1:0]  out_data [2];

    // Acks are gated by reset so nothing is accepted while the block is held in reset.
    assign accept = ap_rst_n & Input_1_V_V_ap_vld & Input_2_V_V_ap_vld & ap_start
                  & (state_reg == ACCUM) & (count_reg < CNT_BITS'(VEC_LEN));
    assign Input_1_V_V_ap_ack = accept;
    assign Input_2_V_V_ap_ack = accept;

    stream_dot_mac #(
        .DATA_BITS (DATA_BITS),
        .ACC_BITS  (ACC_BITS)
    ) u_mac (
        .clk      (ap_clk),
        .rst_n    (ap_rst_n),
        .accept   (accept),
        .clear    (clear),
        .a        (Input_1_V_V),
        .b        (Input_2_V_V),
        .prod_vld (prod_vld),
        .acc      (acc)
    );

    if (DATA_BITS == DATA_BITS_DEF) begin : g_split_pkg
        result_words_t words;
        assign words          = split_result(acc);
        assign result_word[0] = words.lo;
        assign result_word[1] = words.hi;
    end else begin : g_split_slice
        assign result_word[0] = acc[DATA_BITS-1:0];
        assign result_word[1] = acc[ACC_BITS-1:DATA_BITS];
    end

    assign out_ack = {Output_2_V_V_ap_ack, Output_1_V_V_ap_ack};

    // Lane 0 carries the low word, lane 1 the high word; each retires on its own handshake.
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        logic                 vld_reg;
        logic [DATA_BITS-1:0] data_reg;

        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                vld_reg  <= 1'b0;
                data_reg <= '0;
            end else if (load) begin
                vld_reg  <= 1'b1;
                data_reg <= result_word[gi];
            end else if (vld_reg && out_ack[gi]) begin
                vld_reg  <= 1'b0;
            end
        end

        assign out_vld[gi]   = vld_reg;
        assign out_data[gi]  = data_reg;
        assign lane_free[gi] = ~vld_reg | out_ack[gi];
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_reg <= ACCUM;
            count_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        done_next  = 1'b0;
        load       = 1'b0;
        clear      = 1'b0;
        case (state_reg)
            ACCUM: begin
                if (accept) begin
                    count_next = count_reg + CNT_BITS'(1);
                    if (count_reg == CNT_BITS'(VEC_LEN - 1)) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Empty product register means the final accumulate has landed.
                if (!prod_vld) begin
                    load       = 1'b1;
                    state_next = OUT;
                end
            end
            OUT: begin
                if (&lane_free) begin
                    done_next  = 1'b1;
                    clear      = 1'b1;
                    count_next = '0;
                    state_next = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    assign ap_idle             = (state_reg == ACCUM) && (count_reg == '0) && !prod_vld;
    assign ap_done             = done_reg;
    assign ap_ready            = done_reg;
    assign Output_1_V_V        = out_data[0];
    assign Output_1_V_V_ap_vld = out_vld[0];
    assign Output_2_V_V        = out_data[1];
    assign Output_2_V_V_ap_vld = out_vld[1];

`ifdef STREAM_DOT_VECCNT_EN
    logic [31:0] vec_count_reg;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            vec_count_reg <= '0;
        end else if (done_next) begin
            vec_count_reg <= vec_count_reg + 32'd1;
        end
    end

    assign vec_count = vec_count_reg;
`endif

endmodule

// File: tb/tb_stream_dot_product.sv
// Self-checking bench for stream_dot_product with VEC_LEN=4.
// Expected results are pushed to a scoreboard queue when a vector is driven and popped on output.
module tb_stream_dot_product;

    localparam int DW = 32;
    localparam int VL = 4;

    logic          ap_clk   = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic          ap_start = 1'b0;
    logic          ap_idle, ap_done, ap_ready;
    logic [DW-1:0] Input_1_V_V = '0;
    logic          Input_1_V_V_ap_vld = 1'b0;
    logic          Input_1_V_V_ap_ack;
    logic [DW-1:0] Input_2_V_V = '0;
    logic          Input_2_V_V_ap_vld = 1'b0;
    logic          Input_2_V_V_ap_ack;
    logic [DW-1:0] Output_1_V_V;
    logic          Output_1_V_V_ap_vld;
    logic          Output_1_V_V_ap_ack = 1'b0;
    logic [DW-1:0] Output_2_V_V;
    logic          Output_2_V_V_ap_vld;
    logic          Output_2_V_V_ap_ack = 1'b0;
`ifdef STREAM_DOT_VECCNT_EN
    logic [31:0]   vec_count;
`endif

    stream_dot_product #(
        .DATA_BITS (DW),
        .VEC_LEN   (VL)
    ) dut (
        .ap_clk              (ap_clk),
        .ap_rst_n            (ap_rst_n),
        .ap_start            (ap_start),
        .ap_idle             (ap_idle),
        .ap_done             (ap_done),
        .ap_ready            (ap_ready),
        .Input_1_V_V         (Input_1_V_V),
        .Input_1_V_V_ap_vld  (Input_1_V_V_ap_vld),
        .Input_1_V_V_ap_ack  (Input_1_V_V_ap_ack),
        .Input_2_V_V         (Input_2_V_V),
        .Input_2_V_V_ap_vld  (Input_2_V_V_ap_vld),
        .Input_2_V_V_ap_ack  (Input_2_V_V_ap_ack),
        .Output_1_V_V        (Output_1_V_V),
        .Output_1_V_V_ap_vld (Output_1_V_V_ap_vld),
        .Output_1_V_V_ap_ack (Output_1_V_V_ap_ack),
        .Output_2_V_V        (Output_2_V_V),
        .Output_2_V_V_ap_vld (Output_2_V_V_ap_vld),
        .Output_2_V_V_ap_ack (Output_2_V_V_ap_ack)
`ifdef STREAM_DOT_VECCNT_EN
       ,.vec_count           (vec_count)
`endif
    );

    always #5 ap_clk = ~ap_clk;

    int cyc = 0;
    always @(posedge ap_clk) cyc <= cyc + 1;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [63:0] sb [$];
    int          last_hs  = 0;
    int          first_hs = 0;

    // Presents one pair and holds it until the DUT acks; entered and left on a negedge.
    task automatic send_pair(input int a, input int b, output bit to);
        Input_1_V_V = a;
        Input_2_V_V = b;
        Input_1_V_V_ap_vld = 1'b1;
        Input_2_V_V_ap_vld = 1'b1;
        to = 1'b1;
        for (int i = 0; i < 40 && to; i++) begin
            #1;
            if (Input_1_V_V_ap_ack && Input_2_V_V_ap_ack) begin
                to = 1'b0;
                last_hs = cyc + 1;
            end
            @(negedge ap_clk);
        end
        Input_1_V_V_ap_vld = 1'b0;
        Input_2_V_V_ap_vld = 1'b0;
    endtask

    task automatic send_vector(input int a [VL], input int b [VL], output bit to);
        longint s;
        bit     t1;
        s  = 0;
        to = 1'b0;
        for (int i = 0; i < VL; i++) s += longint'(a[i]) * longint'(b[i]);
        sb.push_back(64'(s));
        for (int i = 0; i < VL; i++) begin
            send_pair(a[i], b[i], t1);
            if (i == 0) first_hs = last_hs;
            to |= t1;
        end
    endtask

    // Waits (bounded) for both result words to be valid and captures them; no acks driven.
    task automatic wait_result(output logic [63:0] r, output int vld_edge, output bit to);
        to = 1'b1;
        r = '0;
        vld_edge = 0;
        for (int i = 0; i < 40; i++) begin
            if (Output_1_V_V_ap_vld && Output_2_V_V_ap_vld) begin
                r = {Output_2_V_V, Output_1_V_V};
                vld_edge = cyc;
                to = 1'b0;
                break;
            end
            @(negedge ap_clk);
        end
        $display("[%0t] result 0x%016h", $time, r);
    endtask

    task automatic ack_both();
        Output_1_V_V_ap_ack = 1'b1;
        Output_2_V_V_ap_ack = 1'b1;
        @(negedge ap_clk);
        Output_1_V_V_ap_ack = 1'b0;
        Output_2_V_V_ap_ack = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] st;
        Input_1_V_V_ap_vld = 1'b1;
        Input_2_V_V_ap_vld = 1'b1;
        ap_start = 1'b1;
        @(negedge ap_clk);
        #1;
        st = {Input_1_V_V_ap_ack, Input_2_V_V_ap_ack, Output_1_V_V_ap_vld,
              Output_2_V_V_ap_vld, ap_done, ap_ready, ap_idle};
        n_cmp++;
        if (st !== 7'b0000001) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want %b", st, 7'b0000001);
        end
        n_cmp++;
        if ({Output_2_V_V, Output_1_V_V} !== 64'h0) begin
            n_fail++; $display("FAIL reset_data: got %h want 0", {Output_2_V_V, Output_1_V_V});
        end
        Input_1_V_V_ap_vld = 1'b0;
        Input_2_V_V_ap_vld = 1'b0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        n_cmp++;
        if (ap_idle !== 1'b1) begin
            n_fail++; $display("FAIL reset_idle: got %b want 1", ap_idle);
        end
    endtask

    task automatic test_basic();
        int a [VL], b [VL];
        logic [63:0] r, e;
        int ve, hs;
        bit to, to2;
        a = '{1, 2, 3, 4};
        b = '{5, 6, 7, 8};
        send_vector(a, b, to);
        hs = last_hs;
        wait_result(r, ve, to2);
        e = sb.pop_front();
        n_cmp++;
        if (to || to2 || r !== e || e !== 64'd70) begin
            n_fail++; $display("FAIL basic_result: got %h (to=%0b/%0b) want %h", r, to, to2, e);
        end
        n_cmp++;
        if (ve - hs != 2) begin
            n_fail++; $display("FAIL basic_latency: got %0d want 2", ve - hs);
        end
        ack_both();
        n_cmp++;
        if ({ap_done, ap_ready} !== 2'b11) begin
            n_fail++; $display("FAIL done_pulse: got %b want 11", {ap_done, ap_ready});
        end
        @(negedge ap_clk);
        n_cmp++;
        if ({ap_done, ap_ready, ap_idle} !== 3'b001) begin
            n_fail++; $display("FAIL done_single: got %b want 001", {ap_done, ap_ready, ap_idle});
        end
    endtask

    task automatic test_values(input int av, input int bv, input logic [63:0] want, input string nm);
        int a [VL], b [VL];
        logic [63:0] r, e;
        int ve;
        bit to, to2;
        for (int i = 0; i < VL; i++) begin a[i] = av; b[i] = bv; end
        send_vector(a, b, to);
        wait_result(r, ve, to2);
        e = sb.pop_front();
        n_cmp++;
        if (to || to2 || r !== e || r !== want) begin
            n_fail++; $display("FAIL %s: got %h want %h", nm, r, want);
        end
        ack_both();
    endtask

    task automatic test_one_sided();
        logic [63:0] r, e;
        int ve, t0;
        bit to, to2, stuck;
        stuck = 1'b0;
        Input_1_V_V = 32'd3;
        Input_1_V_V_ap_vld = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (Input_1_V_V_ap_ack || Input_2_V_V_ap_ack) stuck = 1'b1;
            @(negedge ap_clk);
        end
        n_cmp++;
        if (stuck !== 1'b0) begin
            n_fail++; $display("FAIL one_sided_ack: got %b want 0", stuck);
        end
        sb.push_back(64'd15);
        t0 = cyc;
        send_pair(3, 4, to);
        n_cmp++;
        if (to || last_hs != t0 + 1) begin
            n_fail++; $display("FAIL one_sided_accept: got edge %0d want %0d", last_hs, t0 + 1);
        end
        for (int i = 1; i < VL; i++) send_pair(1, 1, to);
        wait_result(r, ve, to2);
        e = sb.pop_front();
        n_cmp++;
        if (to2 || r !== e) begin
            n_fail++; $display("FAIL one_sided_result: got %h want %h", r, e);
        end
        ack_both();
    endtask

    task automatic test_pause();
        logic [63:0] r, e;
        int ve;
        bit to, to2, leak;
        leak = 1'b0;
        sb.push_back(64'd2 * 9 + 64'd4 * 5 + 64'd6 * 7 + 64'd3 * 3);
        send_pair(2, 9, to);
        send_pair(4, 5, to);
        ap_start = 1'b0;
        Input_1_V_V = 32'd6; Input_2_V_V = 32'd7;
        Input_1_V_V_ap_vld = 1'b1; Input_2_V_V_ap_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (Input_1_V_V_ap_ack || Input_2_V_V_ap_ack) leak = 1'b1;
            @(negedge ap_clk);
        end
        n_cmp++;
        if (leak !== 1'b0) begin
            n_fail++; $display("FAIL pause_ack: got %b want 0", leak);
        end
        ap_start = 1'b1;
        send_pair(6, 7, to);
        send_pair(3, 3, to);
        wait_result(r, ve, to2);
        e = sb.pop_front();
        n_cmp++;
        if (to || to2 || r !== e) begin
            n_fail++; $display("FAIL pause_result: got %h want %h", r, e);
        end
        ack_both();
    endtask

    task automatic test_delayed_ack();
        int a [VL], b [VL], a2 [VL], b2 [VL];
        logic [63:0] r, e;
        logic [31:0] hi;
        int ve, bad;
        bit to, to2;
        for (int i = 0; i < VL; i++) begin
            a[i] = int'($urandom); b[i] = int'($urandom);
            a2[i] = int'($urandom); b2[i] = int'($urandom);
        end
        send_vector(a, b, to);
        wait_result(r, ve, to2);
        e = sb.pop_front();
        n_cmp++;
        if (to || to2 || r !== e) begin
            n_fail++; $display("FAIL delayed_result: got %h want %h", r, e);
        end
        hi = Output_2_V_V;
        Output_1_V_V_ap_ack = 1'b1;
        @(negedge ap_clk);
        Output_1_V_V_ap_ack = 1'b0;
        n_cmp++;
        if ({Output_1_V_V_ap_vld, Output_2_V_V_ap_vld} !== 2'b01) begin
            n_fail++; $display("FAIL lo_drop: got %b want 01", {Output_1_V_V_ap_vld, Output_2_V_V_ap_vld});
        end
        Input_1_V_V = a2[0]; Input_2_V_V = b2[0];
        Input_1_V_V_ap_vld = 1'b1; Input_2_V_V_ap_vld = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (!Output_2_V_V_ap_vld || Output_2_V_V !== hi || Input_1_V_V_ap_ack || Input_2_V_V_ap_ack)
                bad++;
            @(negedge ap_clk);
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++; $display("FAIL hi_hold: got %0d bad cycles want 0", bad);
        end
        Output_2_V_V_ap_ack = 1'b1;
        @(negedge ap_clk);
        Output_2_V_V_ap_ack = 1'b0;
        #1;
        n_cmp++;
        if ({ap_done, Input_1_V_V_ap_ack, Input_2_V_V_ap_ack} !== 3'b111) begin
            n_fail++; $display("FAIL resume: got %b want 111", {ap_done, Input_1_V_V_ap_ack, Input_2_V_V_ap_ack});
        end
        send_vector(a2, b2, to);
        wait_result(r, ve, to2);
        e = sb.pop_front();
        n_cmp++;
        if (to || to2 || r !== e) begin
            n_fail++; $display("FAIL resume_result: got %h want %h", r, e);
        end
        ack_both();
    endtask

    task automatic test_back_to_back();
        int a [VL], b [VL];
        logic [63:0] r, e;
        int ve, out_edge;
        bit to, to2;
        for (int i = 0; i < VL; i++) begin a[i] = i - 2; b[i] = 7 * i + 1; end
        send_vector(a, b, to);
        wait_result(r, ve, to2);
        e = sb.pop_front();
        n_cmp++;
        if (to || to2 || r !== e) begin
            n_fail++; $display("FAIL b2b_result: got %h want %h", r, e);
        end
        out_edge = cyc + 1;
        ack_both();
        for (int i = 0; i < VL; i++) begin a[i] = 100 + i; b[i] = -3; end
        send_vector(a, b, to);
        n_cmp++;
        if (to || first_hs != out_edge + 1) begin
            n_fail++; $display("FAIL b2b_first_ack: got edge %0d want %0d", first_hs, out_edge + 1);
        end
        wait_result(r, ve, to2);
        e = sb.pop_front();
        n_cmp++;
        if (to2 || r !== e) begin
            n_fail++; $display("FAIL b2b_second: got %h want %h", r, e);
        end
        ack_both();
    endtask

    task automatic test_reset_mid();
        int a [VL], b [VL];
        logic [63:0] r, e;
        logic [4:0] st;
        int ve;
        bit to, to2;
        send_pair(9, 9, to);
        send_pair(7, 7, to);
        Input_1_V_V_ap_vld = 1'b1; Input_2_V_V_ap_vld = 1'b1;
        ap_rst_n = 1'b0;
        #1;
        st = {Input_1_V_V_ap_ack, Input_2_V_V_ap_ack, Output_1_V_V_ap_vld, Output_2_V_V_ap_vld, ap_done};
        n_cmp++;
        if (st !== 5'b0 || ap_idle !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset: got %b idle %b want 00000 idle 1", st, ap_idle);
        end
        @(negedge ap_clk);
        Input_1_V_V_ap_vld = 1'b0; Input_2_V_V_ap_vld = 1'b0;
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        for (int i = 0; i < VL; i++) begin a[i] = 1; b[i] = 1; end
        send_vector(a, b, to);
        wait_result(r, ve, to2);
        e = sb.pop_front();
        n_cmp++;
        if (to || to2 || r !== e || r !== 64'd4) begin
            n_fail++; $display("FAIL post_reset: got %h want %h", r, e);
        end
        ack_both();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_values(-1, 1, 64'hFFFF_FFFF_FFFF_FFFC, "neg_result");
        test_values(int'(32'h8000_0000), int'(32'h8000_0000), 64'h0, "wrap_result");
        test_one_sided();
        test_pause();
        test_delayed_ack();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
